// File: rtl/k_half_adder_pkg.sv
// Shared constants for the lane-parallel half adder: default sizing and the
// per-lane truth table, indexed by {a,b} and yielding {c_out,sum}.
package k_half_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Entry index {a,b}: 00->00, 01->01, 10->01, 11->10 (as {c_out,sum}).
  localparam logic [3:0][1:0] HA_TT = {2'b10, 2'b01, 2'b01, 2'b00};

endpackage

// File: rtl/k_half_adder_lane.sv
// Single 1-bit half-adder cell; purely combinational.
module k_half_adder_lane (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b;
  assign c_out = a & b;

endmodule

// File: rtl/k_half_adder.sv
// Lane-parallel half adder with optional output registers, a valid strobe and
// a saturating count of accepted beats that produced any carry.
module k_half_adder
  import k_half_adder_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned REGISTER_OUT = 1,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] c_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] c_out_c;
  logic             carry_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    k_half_adder_lane u_lane (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum_c[i]),
      .c_out (c_out_c[i])
    );
  end

  if (REGISTER_OUT != 0) begin : g_reg
    // Data registers load only on valid beats so undriven a/b are never captured.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum       <= '0;
        c_out     <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum   <= sum_c;
          c_out <= c_out_c;
        end
      end
    end
  end else begin : g_comb
    assign sum       = sum_c;
    assign c_out     = c_out_c;
    assign out_valid = in_valid;
  end

  // in_valid gates first so X on a/b during idle cycles cannot reach the counter.
  assign carry_hit = in_valid & (|c_out_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      carry_cnt <= '0;
    else if (cnt_clr)
      carry_cnt <= '0;
    else if (carry_hit && (carry_cnt != CNT_MAX))
      carry_cnt <= carry_cnt + 1'b1;
  end

endmodule

// File: tb/tb_k_half_adder.sv
// Bench: a registered 4-lane instance with a 2-bit counter and a combinational
// 4-lane instance with a 16-bit counter share one stimulus stream.
module tb_k_half_adder;
  import k_half_adder_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cnt_clr = 1'b0;

  logic [W-1:0] sum_r, c_out_r, sum_c, c_out_c;
  logic         ov_r, ov_c;
  logic [1:0]   cnt_r;
  logic [15:0]  cnt_c;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [W-1:0] exp_sum, exp_cout;
  logic         exp_ov;
  int           exp_cnt_r, exp_cnt_c;

  always #5 clk = ~clk;

  k_half_adder #(.WIDTH(W), .REGISTER_OUT(1), .CNT_W(2)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .sum(sum_r), .c_out(c_out_r), .out_valid(ov_r), .carry_cnt(cnt_r)
  );

  k_half_adder #(.WIDTH(W), .REGISTER_OUT(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .sum(sum_c), .c_out(c_out_c), .out_valid(ov_c), .carry_cnt(cnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-lane lookup in the package truth table.
  function automatic void ref_ha(input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] s, output logic [W-1:0] c);
    logic [3:0][1:0] tt;
    logic [1:0] e;
    tt = HA_TT;
    s = '0;
    c = '0;
    for (int i = 0; i < W; i++) begin
      e = tt[{x[i], y[i]}];
      s[i] = e[0];
      c[i] = e[1];
    end
  endfunction

  task automatic model_reset();
    exp_sum = '0; exp_cout = '0; exp_ov = 1'b0; exp_cnt_r = 0; exp_cnt_c = 0;
  endtask

  // One beat: drive at negedge, check comb instance, then registered after posedge.
  task automatic beat(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic clr);
    logic [W-1:0] s, c;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; cnt_clr = clr;
    #1;
    if (!$isunknown({ia, ib})) begin
      ref_ha(ia, ib, s, c);
      chk("comb_sum", 32'(sum_c), 32'(s));
      chk("comb_cout", 32'(c_out_c), 32'(c));
    end
    chk("comb_valid", 32'(ov_c), 32'(v));
    @(posedge clk);
    if (v) begin
      ref_ha(ia, ib, s, c);
      exp_sum = s; exp_cout = c;
    end
    exp_ov = v;
    if (clr) begin
      exp_cnt_r = 0; exp_cnt_c = 0;
    end else if (v && (|(ia & ib)) === 1'b1) begin
      if (exp_cnt_r < 3) exp_cnt_r++;
      if (exp_cnt_c < 65535) exp_cnt_c++;
    end
    #1;
    chk("reg_sum", 32'(sum_r), 32'(exp_sum));
    chk("reg_cout", 32'(c_out_r), 32'(exp_cout));
    chk("reg_valid", 32'(ov_r), 32'(exp_ov));
    chk("cnt_r", 32'(cnt_r), 32'(exp_cnt_r));
    chk("cnt_c", 32'(cnt_c), 32'(exp_cnt_c));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // Power-on reset
    rst = 1'b1;
    model_reset();
    #12;
    chk("rst_sum", 32'(sum_r), 32'h0);
    chk("rst_cout", 32'(c_out_r), 32'h0);
    chk("rst_valid", 32'(ov_r), 32'h0);
    chk("rst_cnt", 32'(cnt_r), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Lane-0 truth table walk: 00, 01, 10, 11
    beat(1'b1, 4'b0000, 4'b0000, 1'b0);
    beat(1'b1, 4'b0000, 4'b0001, 1'b0);
    beat(1'b1, 4'b0001, 4'b0000, 1'b0);
    beat(1'b1, 4'b0001, 4'b0001, 1'b0);
    chk("cnt_after_11", 32'(cnt_c), 32'd1);

    // No inter-lane carry
    beat(1'b1, 4'b1100, 4'b1010, 1'b0);
    chk("w4_sum", 32'(sum_r), 32'b0110);
    chk("w4_cout", 32'(c_out_r), 32'b1000);

    // Hold: idle with carry-producing inputs, then idle with X inputs
    beat(1'b0, 4'b1111, 4'b1111, 1'b0);
    beat(1'b0, 'x, 'x, 1'b0);

    // Counter saturation then clear-priority over a carry beat
    beat(1'b0, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, 4'b0010, 4'b0011, 1'b0);
    chk("cnt_sat", 32'(cnt_r), 32'd3);
    beat(1'b1, 4'b1111, 4'b1111, 1'b1);
    chk("cnt_clr_prio", 32'(cnt_r), 32'd0);

    // Asynchronous reset mid-cycle with a beat loaded
    beat(1'b1, 4'b1111, 4'b1111, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sum", 32'(sum_r), 32'h0);
    chk("arst_cout", 32'(c_out_r), 32'h0);
    chk("arst_valid", 32'(ov_r), 32'h0);
    chk("arst_cnt_r", 32'(cnt_r), 32'h0);
    chk("arst_cnt_c", 32'(cnt_c), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    beat(1'b0, 4'b1111, 4'b1111, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0)
        beat(1'b0, ($urandom_range(0, 1) == 0) ? ra : 'x, rb, ($urandom_range(0, 15) == 0));
      else
        beat(1'b1, ra, rb, ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/k_half_adder.md
Name: k_half_adder

Overview:
- Registered, lane-parallel half adder: each lane computes sum = a XOR b and carry-out c_out = a AND b.
- Used as a leaf arithmetic primitive feeding carry-chain and adder-tree logic.
- Results are registered with a valid strobe.
- A saturating carry-event counter is provided for debug and coverage visibility.

Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes.
- REGISTER_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = sum/c_out combinational (zero latency), counter still registered.
- CNT_W, 16, width of the carry-event counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a/b this cycle.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  per-lane a XOR b.
- c_out  output  WIDTH  per-lane a AND b.
- out_valid  output  1  qualifies sum/c_out.
- carry_cnt  output  CNT_W  saturating count of accepted beats with any c_out bit set.
- cnt_clr  input  1  synchronous clear of carry_cnt.

Behaviour:
- Lane i is independent: sum[i] = a[i]^b[i], c_out[i] = a[i]&b[i]. No carry propagates between lanes.
- Truth table per lane (a,b -> sum,c_out): 00->00, 01->10, 10->10, 11->01.
- REGISTER_OUT=1:
  - On each rising clk, sum/c_out/out_valid load the combinational results and in_valid.
  - Latency exactly 1 cycle.
  - sum/c_out update only when in_valid=1, otherwise they hold their previous value.
  - out_valid = in_valid delayed by one cycle.
- REGISTER_OUT=0:
  - sum/c_out follow a/b combinationally regardless of in_valid.
  - out_valid = in_valid.
- Reset (rst=1, asynchronous assert, released synchronously to clk by upstream):
  - sum=0, c_out=0, out_valid=0, carry_cnt=0 immediately, independent of clk.
- Reset mid-operation: an in-flight beat is discarded; out_valid stays 0 on the cycle after deassertion unless in_valid is sampled high on that edge.
- carry_cnt:
  - Increments by 1 on each rising edge with in_valid=1 and |(a&b)=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces 0 on the next edge and has priority over a simultaneous increment.
  - rst has priority over everything.
- X/Z on a/b while in_valid=0 must not disturb registered outputs.
- No backpressure: every valid beat is accepted every cycle.

Decomposition:
- Shared package: default WIDTH and CNT_W constants, plus the truth-table constant used by the bench scoreboard.
- One natural sub-module: k_half_adder_lane, a purely combinational 1-bit a/b -> sum/c_out cell instantiated WIDTH times via generate.
- Output registers, valid pipe and counter live in the top.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> sum=0, c_out=0, out_valid=0, carry_cnt=0 before the next clk edge.
- WIDTH=1, REGISTER_OUT=1: in_valid=1, a=0, b=0, then a=0, b=1 on successive cycles -> one cycle later sum=0/c_out=0, then sum=1/c_out=0, with out_valid=1 each.
- Exhaustive single lane: a,b = 10 then 11 -> sum=1/c_out=0, then sum=0/c_out=1; carry_cnt=1.
- WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, c_out=4'b1000, no inter-lane carry.
- Hold: in_valid=0 with a=b=1 -> sum/c_out unchanged, out_valid=0, carry_cnt unchanged.
- Counter: CNT_W=2, five carry beats -> carry_cnt saturates at 3; cnt_clr together with a carry beat -> carry_cnt=0.
